ex_div: RTL
===========

# ex_div

Iterative 32-bit divider for DIV/DIVU, used by the EX stage directly downstream of the ID/EX pipeline register. Each division runs as a multi-cycle restoring divide, one quotient bit per cycle. While a division is in flight the block requests a pipeline stall. The {remainder, quotient} pair it produces is the HI/LO write data.

## Interface
Parameters: none. The width is fixed by `reg_data_t` (32 bits).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- stall  in  6  pipeline stall vector; bit 3 = EX held
- start_i  in  1  EX holds a DIV/DIVU; level, stays high while the instruction is in EX
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU
- dividend_i  in  32  rs operand
- divisor_i  in  32  rt operand
- annul_i  in  1  flush/exception; aborts any division
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1
- ready_o  out  1  result valid
- stallreq_o  out  1  combinational; = start_i & ~ready_o & ~annul_i

## Operation
- FSM states, kept in `div_state_t`:
  - DIV_FREE (idle)
  - DIV_BY_ZERO
  - DIV_ON
  - DIV_END
- FREE:
  - start_i & ~annul_i & divisor_i = 0 goes to BY_ZERO.
  - start_i & ~annul_i with nonzero divisor goes to ON. On entry, latch the absolute operands (when signed_i = 1), the sign flags and signed_i; clear the 6-bit counter.
- BY_ZERO: result = 0, then go to END.
- ON:
  - Working register is 65 bits, {partial remainder, dividend}.
  - Each cycle: shift left 1, trial-subtract the divisor from bits [64:32]. If non-negative, keep the difference and set quotient bit 1; otherwise restore and set 0.
  - Counter increments each cycle. After the 32nd iteration go to END.
- ON to END, sign fix-up for signed operation:
  - Negate the quotient when the dividend and divisor signs differ.
  - The remainder takes the dividend's sign.
  - The fixed-up values are registered into result_o.
- END:
  - ready_o = 1 and result_o is held stable.
  - Go to FREE in the first cycle with stall[3] = 0, i.e. the instruction leaves EX. A downstream stall keeps END.
- annul_i in any state forces FREE on the next edge; ready_o = 0, result_o = 0. annul_i in FREE suppresses start_i.
- Operands sampled after FREE are ignored. Input changes mid-operation have no effect.
- Arithmetic corner cases:
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - Unsigned operands are never negated.

## Timing
- Reset (async, rst = 0):
  - state = FREE, counter = 0
  - result_o = 0, ready_o = 0, stallreq_o follows its equation
- Let T be the cycle in which FREE sees start_i:
  - Normal divide: ON for T+1..T+32, ready_o high from T+33. stallreq_o is high T..T+32 (33 cycles).
  - Divisor = 0: BY_ZERO at T+1, ready_o from T+2.
- stallreq_o drops in the same cycle ready_o rises, so EX advances on that edge.
- Back-to-back divides: END exits on stall[3] = 0. At the next edge FREE samples the new instruction's start_i, with no bubble beyond the FSM latency.
- Simultaneous annul_i and END: annul wins, and ready_o is 0 the next cycle.

## Configuration
- `DIV_SHORTCUT_EN`:
  - Defined: in FREE, a start with nonzero divisor and |dividend| < |divisor| (unsigned compare of the absolute values) goes directly to END with quotient 0 and remainder = dividend (original sign). ready_o rises at T+1 and stallreq_o is high only in cycle T.
  - Undefined: every nonzero-divisor operation takes the full 32 iterations.
  - Results are identical either way.

## Structure
- Shared package (`project_types`):
  - `div_state_t` enum
  - `DIV_CYCLES` = 32
  - `div_result_t` packed {hi, lo}
- Reuse `reg_data_t`.
- One sub-module: `div_step`, a combinational single iteration (65-bit shift/trial-subtract, outputs the next working register). The FSM, counter, sign handling and output registers stay in ex_div.

## Test plan
- DIVU, 100 / 7, start at T -> stallreq_o high T..T+32; ready_o at T+33; result_o = {32'd2, 32'd14}.
- DIV, 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also check 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- DIVU, 123 / 0 -> BY_ZERO; ready_o at T+2; result_o = 0.
- annul_i pulsed at T+10 during DIVU 1000/3 -> FREE at T+11; ready_o never rises; stallreq_o low once start_i drops. A new DIV starting afterwards completes correctly.
- END with stall[3] = 1 held 3 cycles -> ready_o and result_o stable all 3 cycles; FREE one cycle after stall[3] clears. A back-to-back DIVU 9/3 then gives {0, 3}.
- `DIV_SHORTCUT_EN` defined, DIVU 5 / 9 -> ready_o at T+1, result {5, 0}. Undefined -> ready_o at T+33, same result.

Source files
------------

// File: rtl/ex_div_pkg.sv
// Shared types for the EX-stage divider: register width, divider FSM
// states, iteration count and the packed {hi, lo} result layout.
package project_types;

  typedef logic [31:0] reg_data_t;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'd0,
    DIV_BY_ZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_t;

  localparam int DIV_CYCLES = 32;

  typedef struct packed {
    reg_data_t hi;  // remainder
    reg_data_t lo;  // quotient
  } div_result_t;

  // Magnitude of a two's complement operand; unsigned operands pass through.
  // The most negative value maps onto itself, which reads correctly as an
  // unsigned magnitude of 2^31.
  function automatic reg_data_t abs_val(input reg_data_t v, input logic is_signed);
    return (is_signed && v[31]) ? reg_data_t'(-v) : v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// Bundle between the EX stage and the divider. master = EX side issuing
// the instruction, slave = the divider itself.
interface ex_div_if;
  import project_types::*;

  logic        start_i;
  logic        signed_i;
  reg_data_t   dividend_i;
  reg_data_t   divisor_i;
  logic        annul_i;
  div_result_t result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/ex_div_step.sv
// One restoring-division iteration on the 65-bit {partial remainder,
// dividend} working register: shift left by one, trial-subtract the
// divisor from the upper part, keep or restore, and shift in the
// quotient bit.
module div_step
  import project_types::*;
(
  input  logic [64:0] work_i,
  input  reg_data_t   divisor_i,
  output logic [64:0] work_o
);

  logic        fits;
  logic [32:0] diff;

  // After the shift the upper part is work_i[64:31]; the trial fits when it
  // is at least the divisor, and then the difference is below the divisor,
  // so 33 bits hold it.
  always_comb begin
    fits = (work_i[64:31] >= {2'b00, divisor_i});
    diff = work_i[63:31] - {1'b0, divisor_i};
    if (fits) begin
      work_o = {diff, work_i[30:0], 1'b1};
    end else begin
      work_o = {work_i[63:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div.sv
// Iterative 32-bit DIV/DIVU for the EX stage. Restoring divide, one
// quotient bit per cycle, with a stall request while busy and a
// registered {remainder, quotient} result held until EX advances.
// Optional build macro DIV_SHORTCUT_EN: a start whose dividend magnitude
// is below the divisor magnitude finishes in one cycle.
module ex_div
  import project_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  ex_div_if.slave    dif
);

  localparam logic [5:0] LAST_CNT = 6'(DIV_CYCLES - 1);

  div_state_t  state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  logic [64:0] work_q,    work_d;
  reg_data_t   divisor_q, divisor_d;
  logic        signed_q,  signed_d;
  logic        neg_a_q,   neg_a_d;
  logic        neg_b_q,   neg_b_d;
  div_result_t result_q,  result_d;
  logic        ready_q,   ready_d;

  logic [64:0] step_work;
  reg_data_t   abs_a, abs_b;
  reg_data_t   quot_raw, rem_raw, quot_fix, rem_fix;
  logic        unused_stall;

  // Only the EX hold bit matters here; the rest of the vector is ignored.
  assign unused_stall = &{1'b0, stall[5:4], stall[2:0]};

  assign abs_a = abs_val(dif.dividend_i, dif.signed_i);
  assign abs_b = abs_val(dif.divisor_i,  dif.signed_i);

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (step_work)
  );

  // Sign fix-up applied to the final iteration's output: quotient negated
  // when operand signs differ, remainder follows the dividend's sign.
  assign quot_raw = step_work[31:0];
  assign rem_raw  = step_work[63:32];
  assign quot_fix = (signed_q && (neg_a_q ^ neg_b_q)) ? reg_data_t'(-quot_raw) : quot_raw;
  assign rem_fix  = (signed_q && neg_a_q) ? reg_data_t'(-rem_raw) : rem_raw;

  assign dif.result_o   = result_q;
  assign dif.ready_o    = ready_q;
  assign dif.stallreq_o = dif.start_i & ~ready_q & ~dif.annul_i;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      signed_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      signed_q  <= signed_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and datapath updates; annul overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    signed_d  = signed_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    result_d  = result_q;
    ready_d   = ready_q;

    if (dif.annul_i) begin
      state_d  = DIV_FREE;
      cnt_d    = '0;
      result_d = '0;
      ready_d  = 1'b0;
    end else begin
      unique case (state_q)
        DIV_FREE: begin
          if (dif.start_i) begin
            if (dif.divisor_i == '0) begin
              state_d = DIV_BY_ZERO;
            end
`ifdef DIV_SHORTCUT_EN
            else if (abs_a < abs_b) begin
              // Quotient is zero and the remainder is the dividend as given.
              state_d  = DIV_END;
              result_d = div_result_t'({dif.dividend_i, 32'h0});
              ready_d  = 1'b1;
            end
`endif
            else begin
              state_d   = DIV_ON;
              work_d    = {33'h0, abs_a};
              divisor_d = abs_b;
              signed_d  = dif.signed_i;
              neg_a_d   = dif.dividend_i[31];
              neg_b_d   = dif.divisor_i[31];
              cnt_d     = '0;
            end
          end
        end
        DIV_BY_ZERO: begin
          state_d  = DIV_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
        DIV_ON: begin
          work_d = step_work;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == LAST_CNT) begin
            state_d  = DIV_END;
            result_d = '{hi: rem_fix, lo: quot_fix};
            ready_d  = 1'b1;
          end
        end
        DIV_END: begin
          // Hold the result until the instruction actually leaves EX.
          if (!stall[3]) begin
            state_d  = DIV_FREE;
            result_d = '0;
            ready_d  = 1'b0;
          end
        end
        default: state_d = DIV_FREE;
      endcase
    end
  end

endmodule
